// File: rtl/mem_responder_if.sv
// Bundle of the fetch and load/store handshakes between the CPU datapath
// and the memory responder.
interface mem_responder_if;
  logic        i_i_req;
  logic [15:0] i_i_ad;
  logic [15:0] o_i_insn;
  logic        o_hit;
  logic        i_d_rd;
  logic        i_d_lb;
  logic        i_d_wr;
  logic [15:0] i_d_ad;
  logic [15:0] i_d_wdata;
  logic [15:0] o_d_rdata;
  logic        o_d_rdy;
  logic        o_d_err;
  logic        o_busy;

  modport master (
    output i_i_req, i_i_ad, i_d_rd, i_d_lb, i_d_wr, i_d_ad, i_d_wdata,
    input  o_i_insn, o_hit, o_d_rdata, o_d_rdy, o_d_err, o_busy
  );

  modport slave (
    input  i_i_req, i_i_ad, i_d_rd, i_d_lb, i_d_wr, i_d_ad, i_d_wdata,
    output o_i_insn, o_hit, o_d_rdata, o_d_rdy, o_d_err, o_busy
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory responder: arbitrates instruction fetches and data
// loads/stores onto one synchronous RAM with programmable wait states.
module mem_responder #(
  parameter int    MEM_WORDS   = 4096,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input logic           i_clk,
  input logic           i_rst,
  mem_responder_if.slave bus
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [16:0] WORDS_LIM = 17'(MEM_WORDS);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_RESP} state_t;

  state_t state;
  state_t next_state;

  logic [15:0]   mem [MEM_WORDS];
  logic [15:0]   rd_q;
  logic [AW-1:0] idx_q;
  logic [15:0]   wdata_q;
  logic [15:0]   insn_q;
  logic [15:0]   rdata_q;
  logic [3:0]    wait_cnt;
  logic          is_fetch;
  logic          is_store;
  logic          is_lb;
  logic          byte_hi;
  logic          err_q;

  logic          data_req;
  logic          any_req;
  logic [15:0]   req_ad;
  logic          req_ok;
  logic          resp_fetch;
  logic          resp_data;
  logic [15:0]   word;
  logic [15:0]   load_word;

  // Data side wins arbitration; a waiting fetch is simply re-seen next idle.
  assign data_req = bus.i_d_rd || bus.i_d_wr;
  assign any_req  = data_req || bus.i_i_req;
  assign req_ad   = data_req ? bus.i_d_ad : bus.i_i_ad;
  assign req_ok   = ({2'b00, req_ad[15:1]} < WORDS_LIM);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_req) next_state = (WS != 4'd0) ? S_WAIT : S_ACC;
      S_WAIT:  if (wait_cnt <= 4'd1) next_state = S_ACC;
      S_ACC:   next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    resp_fetch    = (state == S_RESP) && is_fetch;
    resp_data     = (state == S_RESP) && !is_fetch;
    word          = err_q ? 16'h0000 : rd_q;
    load_word     = is_lb ? {8'h00, (byte_hi ? word[15:8] : word[7:0])} : word;
    bus.o_busy    = (state != S_IDLE);
    bus.o_hit     = resp_fetch;
    bus.o_d_rdy   = resp_data;
    bus.o_d_err   = resp_data && err_q;
    bus.o_i_insn  = resp_fetch ? word : insn_q;
    bus.o_d_rdata = (resp_data && !is_store) ? load_word : rdata_q;
  end

  // Request capture, wait countdown, and the held copies of returned data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt <= 4'd0;
      is_fetch <= 1'b0;
      is_store <= 1'b0;
      is_lb    <= 1'b0;
      byte_hi  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= 16'h0000;
      insn_q   <= 16'h0000;
      rdata_q  <= 16'h0000;
    end else begin
      if (state == S_IDLE && any_req) begin
        is_fetch <= !data_req;
        is_store <= bus.i_d_wr;
        is_lb    <= data_req && !bus.i_d_wr && bus.i_d_lb;
        byte_hi  <= req_ad[0];
        err_q    <= !req_ok;
        idx_q    <= req_ad[AW:1];
        wdata_q  <= bus.i_d_wdata;
        wait_cnt <= WS;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (resp_fetch)             insn_q  <= word;
      if (resp_data && !is_store) rdata_q <= load_word;
    end
  end

  // Array port kept reset-free so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (state == S_ACC) begin
      if (is_store && !err_q && !i_rst) mem[idx_q] <= wdata_q;
      rd_q <= mem[idx_q];
    end
  end

endmodule
